// File: rtl/tone_meter_pkg.sv
// Shared constants and helpers for the tone frequency meter.
//   OUT_W_DEFAULT : default width of the reported frequency
//   EDGE_CNT_W    : width of the per-window edge counter
//   sat_inc       : saturating increment of an edge count
//   sat_mul       : edge count times Hz-per-edge, clamped to a limit
package tone_meter_pkg;

  localparam int unsigned OUT_W_DEFAULT = 10;
  localparam int unsigned EDGE_CNT_W    = 16;

  // Increment by 'inc' without wrapping past all-ones.
  function automatic logic [EDGE_CNT_W-1:0] sat_inc(input logic [EDGE_CNT_W-1:0] cnt,
                                                    input logic                  inc);
    if (inc && (cnt != {EDGE_CNT_W{1'b1}})) begin
      return cnt + EDGE_CNT_W'(1);
    end
    return cnt;
  endfunction

  // 64-bit product cannot overflow for a 16-bit count times a 32-bit factor.
  function automatic logic [63:0] sat_mul(input logic [EDGE_CNT_W-1:0] edges,
                                          input logic [31:0]           mult,
                                          input logic [63:0]           limit);
    logic [63:0] product;
    product = {{(64-EDGE_CNT_W){1'b0}}, edges} * {32'b0, mult};
    return (product > limit) ? limit : product;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with rising-edge detector for an asynchronous input.
//   i_clk   : sampling clock
//   i_reset : asynchronous active-low reset
//   i_async : asynchronous input
//   o_level : synchronized level
//   o_rise  : one-cycle pulse on a synchronized 0->1 transition
module edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= i_async;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign o_level = sync2_q;
  assign o_rise  = sync2_q & ~hist_q;

endmodule

// File: rtl/tone_freq_meter.sv
// Gate-window frequency meter for a square-wave tone.
// Counts synchronized rising edges over CLK_HZ/GATE_DIV clock cycles and
// reports edges*GATE_DIV in Hz, saturated to OUT_W bits.
//   i_clk     : system clock
//   i_reset   : asynchronous active-low reset
//   i_enable  : measurement enable; low aborts and holds the current window
//   i_tone    : asynchronous tone input
//   o_freq    : last measured frequency in Hz (saturated)
//   o_valid   : one-cycle pulse when o_freq updates
//   o_present : last result nonzero
//   o_stable  : last two results equal and nonzero
//   o_sat     : last result saturated
module tone_freq_meter
  import tone_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned GATE_DIV = 10,
  parameter int unsigned OUT_W    = OUT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_tone,
  output logic [OUT_W-1:0] o_freq,
  output logic             o_valid,
  output logic             o_present,
  output logic             o_stable,
  output logic             o_sat
);

  localparam int unsigned GATE_CYCLES = CLK_HZ / GATE_DIV;
  localparam int unsigned GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [63:0]       FREQ_MAX  = (64'd1 << OUT_W) - 64'd1;

  generate
    if ((CLK_HZ % GATE_DIV != 0) || (GATE_CYCLES < 2)) begin : g_bad_cfg
      $error("tone_freq_meter: CLK_HZ/GATE_DIV must be an integer >= 2");
    end
  endgenerate

  logic                  rise;
  logic                  tone_level_unused;
  logic [GATE_W-1:0]     gate_q, gate_d;
  logic [EDGE_CNT_W-1:0] edge_q, edge_d;
  logic [EDGE_CNT_W-1:0] edge_total;
  logic [63:0]           product;
  logic [63:0]           freq_clamped;
  logic [OUT_W-1:0]      freq_new;
  logic                  sat_new;
  logic                  terminal;

  logic [OUT_W-1:0]      freq_q;
  logic [OUT_W-1:0]      prev_q;
  logic                  valid_q;
  logic                  present_q;
  logic                  stable_q;
  logic                  sat_q;

  edge_sync u_edge_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_tone),
    .o_level (tone_level_unused),
    .o_rise  (rise)
  );

  always_comb begin
    terminal     = i_enable && (gate_q == GATE_LAST);
    // A rise landing on the terminal cycle belongs to the closing window.
    edge_total   = sat_inc(edge_q, rise);
    product      = {{(64-EDGE_CNT_W){1'b0}}, edge_total} * {32'b0, 32'(GATE_DIV)};
    freq_clamped = sat_mul(edge_total, 32'(GATE_DIV), FREQ_MAX);
    freq_new     = OUT_W'(freq_clamped);
    sat_new      = (freq_clamped != product);

    gate_d = gate_q + GATE_W'(1);
    edge_d = edge_total;
    // Disable wins over the terminal cycle: the window is simply dropped.
    if (!i_enable || terminal) begin
      gate_d = '0;
      edge_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      gate_q    <= '0;
      edge_q    <= '0;
      freq_q    <= '0;
      prev_q    <= '0;
      valid_q   <= 1'b0;
      present_q <= 1'b0;
      stable_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      valid_q <= terminal;
      if (terminal) begin
        freq_q    <= freq_new;
        sat_q     <= sat_new;
        present_q <= (product != 64'd0);
        stable_q  <= (freq_new == prev_q) && (freq_new != '0);
        prev_q    <= freq_new;
      end
    end
  end

  assign o_freq    = freq_q;
  assign o_valid   = valid_q;
  assign o_present = present_q;
  assign o_stable  = stable_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_tone_freq_meter.sv
// Self-checking bench for tone_freq_meter. Main instance uses a 100-cycle
// gate window; a second instance with a 1000-cycle window covers saturation.
module tb_tone_freq_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, tone, en2, tone2;
  logic [9:0] freq, freq2;
  logic       valid, present, stable, sat;
  logic       valid2, present2, stable2, sat2;

  always #5 clk = ~clk;

  tone_freq_meter #(.CLK_HZ(1000), .GATE_DIV(10), .OUT_W(10)) u_dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_enable  (en),
    .i_tone    (tone),
    .o_freq    (freq),
    .o_valid   (valid),
    .o_present (present),
    .o_stable  (stable),
    .o_sat     (sat)
  );

  tone_freq_meter #(.CLK_HZ(10000), .GATE_DIV(10), .OUT_W(10)) u_dut_sat (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_enable  (en2),
    .i_tone    (tone2),
    .o_freq    (freq2),
    .o_valid   (valid2),
    .o_present (present2),
    .o_stable  (stable2),
    .o_sat     (sat2)
  );

  typedef struct {
    logic [9:0]  freq;
    logic        present;
    logic        stable;
    logic        sat;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          mode = 0;  // 0 low, 1 high, 2 period-10 square, 3 driven by main thread
  int          ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] f, input logic p, input logic s, input logic sa,
                      input int unsigned c);
    exp_t e;
    e.freq = f; e.present = p; e.stable = s; e.sat = sa; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("drain_timeout", 32'(sb.size()), 0);
  endtask

  // Tone generators act 2 time units after the edge, after the main thread.
  initial begin
    tone = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: tone = 1'b0;
        1: tone = 1'b1;
        2: begin
          tone = (ph >= 5);
          ph   = (ph == 9) ? 0 : ph + 1;
        end
        default: ;
      endcase
    end
  end

  initial begin
    int ph2 = 0;
    tone2 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph2++;
      if (ph2 == 2) begin
        tone2 = ~tone2;
        ph2   = 0;
      end
    end
  end

  // Scoreboard monitor for the main instance.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid === 1'b1) begin
        check_eq("sb_nonempty_on_valid", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("freq", 32'(freq), 32'(e.freq));
          check_eq("present", 32'(present), 32'(e.present));
          check_eq("stable", 32'(stable), 32'(e.stable));
          check_eq("sat", 32'(sat), 32'(e.sat));
          if (e.cyc != 0) check_eq("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int n;
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; mode = 2;

    // Reset held with the tone toggling.
    tick(20);
    check_eq("rst_freq", 32'(freq), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_present", 32'(present), 0);
    check_eq("rst_stable", 32'(stable), 0);
    check_eq("rst_sat", 32'(sat), 0);
    check_eq("rst_freq2", 32'(freq2), 0);
    rst_n = 1'b1;
    tick(500);
    check_eq("idle_freq", 32'(freq), 0);

    // Period-10 tone: two windows of 100 Hz, second one stable.
    en = 1'b1; k = cyc;
    push(10'd100, 1'b1, 1'b0, 1'b0, k + 100);
    push(10'd100, 1'b1, 1'b1, 1'b0, k + 200);
    drain(250);

    // Abort a window mid-way; outputs hold, no valid.
    tick(49);
    en = 1'b0;
    tick(30);
    check_eq("hold_freq", 32'(freq), 100);
    check_eq("hold_present", 32'(present), 1);
    check_eq("hold_stable", 32'(stable), 1);
    check_eq("hold_sat", 32'(sat), 0);
    en = 1'b1; k = cyc;
    push(10'd100, 1'b1, 1'b1, 1'b0, k + 100);
    drain(150);

    // Reset mid-window clears outputs immediately.
    tick(69);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_freq", 32'(freq), 0);
    check_eq("midrst_present", 32'(present), 0);
    check_eq("midrst_stable", 32'(stable), 0);
    check_eq("midrst_valid", 32'(valid), 0);
    mode = 0;
    tick(3);
    rst_n = 1'b1; mode = 2; ph = 0; k = cyc;
    push(10'd100, 1'b1, 1'b0, 1'b0, k + 100);
    push(10'd100, 1'b1, 1'b1, 1'b0, k + 200);
    drain(250);

    // Constant-high tone: zero edges for three windows.
    en = 1'b0; mode = 1;
    tick(10);
    en = 1'b1; k = cyc;
    push(10'd0, 1'b0, 1'b0, 1'b0, k + 100);
    push(10'd0, 1'b0, 1'b0, 1'b0, k + 200);
    push(10'd0, 1'b0, 1'b0, 1'b0, k + 300);
    drain(350);

    // Single rise landing exactly on the terminal cycle.
    en = 1'b0; mode = 3; tone = 1'b0;
    tick(10);
    en = 1'b1; k = cyc;
    tick(97);
    tone = 1'b1;
    push(10'd10, 1'b1, 1'b0, 1'b0, k + 100);
    push(10'd0, 1'b0, 1'b0, 1'b0, k + 200);
    drain(250);

    // Saturation: 250 edges * 10 Hz exceeds the 10-bit range.
    en = 1'b0; en2 = 1'b1; k = cyc; n = 0;
    while (valid2 !== 1'b1 && n < 1100) begin
      tick(1);
      n++;
    end
    check_eq("sat_valid_seen", 32'(valid2), 1);
    check_eq("sat_valid_cycle", cyc, k + 1000);
    check_eq("sat_freq", 32'(freq2), 1023);
    check_eq("sat_flag", 32'(sat2), 1);
    check_eq("sat_present", 32'(present2), 1);
    check_eq("sat_stable_first", 32'(stable2), 0);
    tick(1);
    n = 0;
    while (valid2 !== 1'b1 && n < 1100) begin
      tick(1);
      n++;
    end
    check_eq("sat2_valid_cycle", cyc, k + 2000);
    check_eq("sat2_stable", 32'(stable2), 1);
    check_eq("sat2_freq", 32'(freq2), 1023);

    check_eq("sb_empty_at_end", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_freq_meter.md
Name: tone_freq_meter

Overview:
Receive-side counterpart of the buzzer clock divider. It measures the frequency of an incoming square-wave tone, such as the divider's output looped back or an external tone, using fixed-length gate windows clocked by the system clock. It reports the result in Hz on the same 10-bit scale the divider takes as its frequency setting. The result feeds self-test and tone-detect logic next to the buzzer path.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
GATE_DIV, 10, gate window = CLK_HZ/GATE_DIV cycles (100 ms default); each counted edge is worth GATE_DIV Hz
OUT_W, 10, width of o_freq; saturation value = 2**OUT_W-1

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  measurement enable; level-sensitive
i_tone  in  1  asynchronous tone input
o_freq  out  OUT_W  last measured frequency in Hz, saturated
o_valid  out  1  one-cycle pulse when o_freq is updated
o_present  out  1  last result nonzero
o_stable  out  1  last two results equal and nonzero
o_sat  out  1  last result saturated

Behaviour:
- Reset (i_reset low, asynchronous): synchronizer flops, gate counter, edge counter, o_freq, o_valid, o_present, o_stable, o_sat and prev-result register all go to 0.
- Synchronizer: 2-flop synchronizer on i_tone, plus one history flop.
  - rise = sync2 & ~hist.
  - A 0->1 on i_tone meeting setup before edge N produces rise in cycle N+2.
- GATE_CYCLES = CLK_HZ/GATE_DIV; must be an integer ≥2 (elaboration check).
- Gate counter: width clog2(GATE_CYCLES); counts 0..GATE_CYCLES-1 and wraps to 0.
- Edge counter: 16-bit, saturating at 0xFFFF; increments on rise.
- Terminal cycle (gate counter == GATE_CYCLES-1):
  - A rise in this cycle is counted into the closing window.
  - The edge counter clears to 0 for the next window.
  - product = total edges * GATE_DIV.
  - o_freq <= min(product, 2**OUT_W-1); o_sat <= (product > 2**OUT_W-1).
  - o_present <= (product != 0).
  - o_stable <= (new o_freq == prev) && new o_freq != 0; then prev <= new o_freq.
  - All outputs update, and o_valid pulses high, in the cycle after the terminal cycle. Latency is one clock.
- First window after reset or enable:
  - Starts with gate counter 0 in the first cycle i_enable is sampled high.
  - o_valid fires exactly GATE_CYCLES cycles after that cycle.
  - prev is 0 at that point, so o_stable stays 0 after the first window.
- i_enable low:
  - Gate and edge counters are held at 0; a partial window is discarded and produces no o_valid.
  - o_freq, o_present, o_stable, o_sat and prev keep their values.
  - The synchronizer keeps running so no stale edge is produced on re-enable.
- Simultaneous enable drop and terminal cycle: the window is discarded (enable wins).
- Constant i_tone, either level: 0 edges, so o_freq = 0 and o_present = 0.

Decomposition:
- Package tone_meter_pkg: OUT_W default, EDGE_CNT_W = 16, and a saturating-multiply helper function.
- Sub-module edge_sync: 2-flop synchronizer plus rise detector. Ports i_clk, i_reset, i_async, o_level, o_rise. Reusable by other input-capture blocks.

Test Plan:
All scenarios use CLK_HZ=1000 and GATE_DIV=10 (GATE_CYCLES=100) unless stated.
1. Hold i_reset low, toggle i_tone -> all outputs 0. Release reset, keep i_enable=0 for 500 cycles -> no o_valid.
2. Enable; drive i_tone with period 10 (5 high/5 low) -> o_valid at cycle 100 with o_freq=100, o_present=1, o_stable=0. Next o_valid at cycle 200 with o_freq=100, o_stable=1.
3. Hold i_tone constant 1 for 3 windows -> o_freq=0, o_present=0, o_stable=0 at each o_valid.
4. CLK_HZ=10000 (GATE_CYCLES=1000); i_tone period 4 -> 250 edges * 10 = 2500, so o_freq=1023 and o_sat=1.
5. Deassert i_enable at cycle 50 of a window, reassert 30 cycles later -> no o_valid for the aborted window; outputs hold 100. Next o_valid arrives exactly 100 cycles after re-enable.
6. Assert reset mid-window at cycle 70 -> outputs clear immediately. After release, the first o_valid arrives 100 cycles after the first enabled cycle. Place a rise exactly on the terminal cycle and confirm it is counted in the closing window, not the next.
